// File: rtl/dmem_access_unit.sv
// Data-memory access unit: converts MEM-stage load/store requests into
// single word-wide bus transactions with byte enables, extends load data,
// stalls the pipeline while a transaction is outstanding, and rejects
// misaligned/illegal accesses or aborts on bus timeout.
module dmem_access_unit #(
    parameter int ADDR_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  MEM_READ,
    input  logic                  MEM_WRITE,
    input  logic [2:0]            FUNC3,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [31:0]           WRITE_DATA,
    output logic [31:0]           READ_DATA,
    output logic                  BUSY,
    output logic                  MISALIGN,
    output logic                  BUS_ERR,
    output logic                  DMEM_REQ,
    output logic                  DMEM_WE,
    output logic [3:0]            DMEM_BE,
    output logic [ADDR_WIDTH-1:0] DMEM_ADDR,
    output logic [31:0]           DMEM_WDATA,
    input  logic [31:0]           DMEM_RDATA,
    input  logic                  DMEM_ACK
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Counter only needs to reach TIMEOUT_CYCLES-1; a width of 1 covers the disabled case.
    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            state, state_nxt;
    logic [CNT_W-1:0]  wait_cnt;
    logic [2:0]        func3_q;
    logic [1:0]        lane_q;
    logic              bus_err_q;
    logic              access_req;
    logic              illegal;
    logic              start;
    logic              timeout_hit;
    logic [3:0]        be_nxt;
    logic [31:0]       wdata_nxt;

    // Pick the addressed byte/half out of the bus word and sign- or zero-extend it.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [2:0]  f3,
                                                input logic [1:0]  lane);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        case (lane)
            2'd0:    b = word[7:0];
            2'd1:    b = word[15:8];
            2'd2:    b = word[23:16];
            default: b = word[31:24];
        endcase
        h = lane[1] ? word[31:16] : word[15:0];
        case (f3)
            3'b000:  r = {{24{b[7]}}, b};
            3'b001:  r = {{16{h[15]}}, h};
            3'b100:  r = {24'b0, b};
            3'b101:  r = {16'b0, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Request decode: legality, lane placement of store data and byte enables.
    always_comb begin
        logic f3_bad;
        logic size_bad;
        access_req = MEM_READ | MEM_WRITE;
        if (MEM_WRITE) begin
            f3_bad = FUNC3[2] | (FUNC3[1:0] == 2'b11);
        end else begin
            f3_bad = (FUNC3 == 3'b011) || (FUNC3 == 3'b110) || (FUNC3 == 3'b111);
        end
        size_bad = ((FUNC3[1:0] == 2'b01) && ADDR[0]) ||
                   ((FUNC3[1:0] == 2'b10) && (ADDR[1:0] != 2'b00));
        illegal  = (MEM_READ & MEM_WRITE) | f3_bad | size_bad;
        start    = (state == ST_IDLE) && access_req && !illegal;

        be_nxt    = 4'b1111;
        wdata_nxt = WRITE_DATA;
        if (MEM_WRITE) begin
            case (FUNC3[1:0])
                2'b00: begin
                    be_nxt    = 4'b0001 << ADDR[1:0];
                    wdata_nxt = {4{WRITE_DATA[7:0]}};
                end
                2'b01: begin
                    be_nxt    = 4'b0011 << ADDR[1:0];
                    wdata_nxt = {2{WRITE_DATA[15:0]}};
                end
                default: begin
                    be_nxt    = 4'b1111;
                    wdata_nxt = WRITE_DATA;
                end
            endcase
        end

        // ACK on the final count takes priority over the abort.
        timeout_hit = (TIMEOUT_CYCLES != 0) && !DMEM_ACK && (wait_cnt == CNT_LAST);
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_nxt = state;
        BUSY      = 1'b0;
        MISALIGN  = 1'b0;
        DMEM_REQ  = 1'b0;
        BUS_ERR   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (access_req && illegal) begin
                    MISALIGN = 1'b1;
                end else if (start) begin
                    BUSY      = 1'b1;
                    state_nxt = ST_WAIT;
                end
            end
            ST_WAIT: begin
                BUSY     = 1'b1;
                DMEM_REQ = 1'b1;
                if (DMEM_ACK || timeout_hit) state_nxt = ST_DONE;
            end
            ST_DONE: begin
                BUS_ERR   = bus_err_q;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Transaction capture, timeout counting and load-result update.
    always_ff @(posedge CLK) begin
        if (RST) begin
            READ_DATA  <= '0;
            DMEM_WE    <= 1'b0;
            DMEM_BE    <= '0;
            DMEM_ADDR  <= '0;
            DMEM_WDATA <= '0;
            func3_q    <= '0;
            lane_q     <= '0;
            wait_cnt   <= '0;
            bus_err_q  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        DMEM_WE    <= MEM_WRITE;
                        DMEM_BE    <= be_nxt;
                        DMEM_ADDR  <= {ADDR[ADDR_WIDTH-1:2], 2'b00};
                        DMEM_WDATA <= wdata_nxt;
                        func3_q    <= FUNC3;
                        lane_q     <= ADDR[1:0];
                        wait_cnt   <= '0;
                        bus_err_q  <= 1'b0;
                    end
                end
                ST_WAIT: begin
                    if (DMEM_ACK) begin
                        if (!DMEM_WE) READ_DATA <= extend_load(DMEM_RDATA, func3_q, lane_q);
                    end else if (timeout_hit) begin
                        bus_err_q <= 1'b1;
                        if (!DMEM_WE) READ_DATA <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: bus_err_q <= 1'b0;
            endcase
        end
    end

endmodule
